// File: rtl/grant_sequencer_pkg.sv
// Shared types and helpers for the grant sequencer: the FSM state encoding
// and the code-to-one-hot conversion used when a requester is granted.
package grant_seq_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // Turn a 2-bit requester code into its one-hot grant vector.
   function automatic logic [3:0] onehot4(input logic [1:0] code);
      logic [3:0] v;
      v       = 4'b0000;
      v[code] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/grant_sequencer_if.sv
// Bundle of the encoder-side inputs and the grant-side outputs of the
// grant sequencer. The master side is the requester/encoder environment,
// the slave side is the sequencer itself.
interface grant_sequencer_if #(
   parameter int CNT_W = 8
);

   logic             e0;
   logic             e1;
   logic             nr;
   logic             done;
   logic [3:0]       gnt;
   logic [1:0]       idx;
   logic             busy;
   logic             timeout;
   logic [CNT_W-1:0] served_cnt;

   modport master (
      output e0, e1, nr, done,
      input  gnt, idx, busy, timeout, served_cnt
   );

   modport slave (
      input  e0, e1, nr, done,
      output gnt, idx, busy, timeout, served_cnt
   );

endinterface

// File: rtl/grant_sequencer_hold_timer.sv
// Counts how many cycles the current grant has been held and flags the
// last permitted cycle, so the sequencer can force a release.
module hold_timer #(
   parameter int HOLD_MAX = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int TW = $clog2(HOLD_MAX + 1);

   logic [TW-1:0] timer;

   // Hold-time counter: cleared outside GRANT, advanced once per held cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (clear) begin
         timer <= '0;
      end else if (enable) begin
         timer <= timer + TW'(1);
      end
   end

   assign expire = (timer == TW'(HOLD_MAX - 1));

endmodule

// File: rtl/grant_sequencer.sv
// Grant sequencer: samples the priority-encoded request, grants exactly one
// requester until it signals done or the hold limit expires, then inserts a
// one-cycle release gap. Completed services are counted with saturation.
module grant_sequencer
   import grant_seq_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   grant_sequencer_if.slave   bus
);

   state_t           state, state_next;
   logic [3:0]       gnt_q, gnt_next;
   logic [1:0]       idx_q, idx_next;
   logic             busy_q, busy_next;
   logic             timeout_q, timeout_next;
   logic [CNT_W-1:0] cnt_q, cnt_next;
   logic             timer_clear, timer_en, timer_expire;

   hold_timer #(.HOLD_MAX(HOLD_MAX)) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (timer_clear),
      .enable (timer_en),
      .expire (timer_expire)
   );

   // State and all visible outputs are registered together so every output
   // changes only on a clock edge (or immediately on reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt_q     <= 4'b0000;
         idx_q     <= 2'b00;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state     <= state_next;
         gnt_q     <= gnt_next;
         idx_q     <= idx_next;
         busy_q    <= busy_next;
         timeout_q <= timeout_next;
         cnt_q     <= cnt_next;
      end
   end

   // Next-state and next-output decisions; done beats the hold limit when
   // both land in the same cycle, and the timeout flag is a single pulse.
   always_comb begin
      state_next   = state;
      gnt_next     = gnt_q;
      idx_next     = idx_q;
      busy_next    = busy_q;
      timeout_next = 1'b0;
      cnt_next     = cnt_q;
      timer_clear  = 1'b0;
      timer_en     = 1'b0;
      case (state)
         IDLE: begin
            timer_clear = 1'b1;
            if (!bus.nr) begin
               idx_next   = {bus.e1, bus.e0};
               gnt_next   = onehot4({bus.e1, bus.e0});
               busy_next  = 1'b1;
               state_next = GRANT;
            end
         end
         GRANT: begin
            if (bus.done) begin
               gnt_next   = 4'b0000;
               if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_next = cnt_q + CNT_W'(1);
               end
               state_next = RELEASE;
            end else if (timer_expire) begin
               gnt_next     = 4'b0000;
               timeout_next = 1'b1;
               state_next   = RELEASE;
            end else begin
               timer_en = 1'b1;
            end
         end
         RELEASE: begin
            timer_clear = 1'b1;
            busy_next   = 1'b0;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.gnt        = gnt_q;
   assign bus.idx        = idx_q;
   assign bus.busy       = busy_q;
   assign bus.timeout    = timeout_q;
   assign bus.served_cnt = cnt_q;

endmodule

// File: tb/tb_grant_sequencer.sv
// Self-checking bench for grant_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// service-level model of the grant protocol.
module tb_grant_sequencer;

   localparam int HOLD_MAX = 8;
   localparam int CNT_W    = 2;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   grant_sequencer_if #(.CNT_W(CNT_W)) bus ();

   grant_sequencer #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;
   bit check_en     = 1'b0;

   // Service-level model: who holds the grant, how many cycles it has been
   // visible, and whether the mandatory gap cycle is in progress.
   bit         m_granting = 1'b0;
   bit         m_gap      = 1'b0;
   int         m_shown    = 0;
   int         m_code     = 0;
   logic [3:0] exp_gnt     = 4'b0000;
   logic [1:0] exp_idx     = 2'b00;
   logic       exp_busy    = 1'b0;
   logic       exp_timeout = 1'b0;
   int         exp_cnt     = 0;

   int gnt_cycles = 0;
   int to_pulses  = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests_run++;
      if (actual != expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic nr, input logic [1:0] code, input logic done);
      @(negedge clk);
      bus.nr   = nr;
      bus.e1   = code[1];
      bus.e0   = code[0];
      bus.done = done;
   endtask

   task automatic clearTally();
      @(posedge clk);
      gnt_cycles = 0;
      to_pulses  = 0;
   endtask

   task automatic modelReset();
      m_granting  = 1'b0;
      m_gap       = 1'b0;
      m_shown     = 0;
      exp_gnt     = 4'b0000;
      exp_idx     = 2'b00;
      exp_busy    = 1'b0;
      exp_timeout = 1'b0;
      exp_cnt     = 0;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Reset clears the model at once, mirroring the asynchronous reset.
   always @(negedge rst_n) modelReset();

   // Advance the model one clock using the inputs that were stable at the edge.
   always @(posedge clk) begin
      if (rst_n) begin
         exp_timeout = 1'b0;
         if (m_gap) begin
            m_gap    = 1'b0;
            exp_busy = 1'b0;
         end else if (m_granting) begin
            if (bus.done) begin
               m_granting = 1'b0;
               m_gap      = 1'b1;
               exp_gnt    = 4'b0000;
               if (exp_cnt < CNT_MAX) exp_cnt++;
            end else if (m_shown == HOLD_MAX) begin
               m_granting  = 1'b0;
               m_gap       = 1'b1;
               exp_gnt     = 4'b0000;
               exp_timeout = 1'b1;
            end else begin
               m_shown++;
            end
         end else if (!bus.nr) begin
            m_code     = {30'd0, bus.e1, bus.e0};
            exp_idx    = 2'(m_code);
            exp_gnt    = 4'(1 << m_code);
            exp_busy   = 1'b1;
            m_granting = 1'b1;
            m_shown    = 1;
         end
      end
   end

   // Compare every DUT output against the model once per cycle.
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("gnt",        int'(bus.gnt),        int'(exp_gnt));
         checkOutput("idx",        int'(bus.idx),        int'(exp_idx));
         checkOutput("busy",       int'(bus.busy),       int'(exp_busy));
         checkOutput("timeout",    int'(bus.timeout),    int'(exp_timeout));
         checkOutput("served_cnt", int'(bus.served_cnt), exp_cnt);
         checkOutput("gnt_onehot", int'($countones(bus.gnt) <= 1), 1);
      end
   end

   // Tally grant-visible cycles and timeout cycles for the directed scenarios.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.gnt != 4'b0000) gnt_cycles++;
         if (bus.timeout)        to_pulses++;
      end
   end

   initial begin
      bus.nr   = 1'b1;
      bus.e0   = 1'b0;
      bus.e1   = 1'b0;
      bus.done = 1'b0;

      // Reset state
      #1 rst_n = 1'b0;
      #1 check_en = 1'b1;
      #1;
      checkOutput("rst_gnt",     int'(bus.gnt),        0);
      checkOutput("rst_idx",     int'(bus.idx),        0);
      checkOutput("rst_busy",    int'(bus.busy),       0);
      checkOutput("rst_timeout", int'(bus.timeout),    0);
      checkOutput("rst_cnt",     int'(bus.served_cnt), 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (5) applyStimulus(1'b1, 2'b00, 1'b0);
      #1;
      checkOutput("idle_gnt",  int'(bus.gnt),  0);
      checkOutput("idle_busy", int'(bus.busy), 0);

      // Normal service, done on the third grant cycle
      clearTally();
      applyStimulus(1'b0, 2'b11, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0);
      #1 checkOutput("svc_gnt", int'(bus.gnt), 8);
      applyStimulus(1'b1, 2'b00, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b1);
      repeat (3) applyStimulus(1'b1, 2'b00, 1'b0);
      @(posedge clk);
      checkOutput("svc_gnt_cycles", gnt_cycles, 3);
      checkOutput("svc_timeouts",   to_pulses,  0);
      checkOutput("svc_cnt",        int'(bus.served_cnt), 1);

      // Timeout with no done
      clearTally();
      applyStimulus(1'b0, 2'b01, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0);
      #1 checkOutput("to_gnt", int'(bus.gnt), 2);
      repeat (11) applyStimulus(1'b1, 2'b00, 1'b0);
      @(posedge clk);
      checkOutput("to_gnt_cycles", gnt_cycles, 8);
      checkOutput("to_pulses",     to_pulses,  1);
      checkOutput("to_cnt",        int'(bus.served_cnt), 1);

      // Done in the final hold cycle, code changing underneath the grant
      clearTally();
      applyStimulus(1'b0, 2'b10, 1'b0);
      repeat (3) applyStimulus(1'b0, 2'b00, 1'b0);
      #1 checkOutput("frozen_gnt", int'(bus.gnt), 4);
      repeat (4) applyStimulus(1'b0, 2'b00, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b1);
      repeat (4) applyStimulus(1'b1, 2'b00, 1'b0);
      @(posedge clk);
      checkOutput("sim_gnt_cycles", gnt_cycles, 8);
      checkOutput("sim_timeouts",   to_pulses,  0);
      checkOutput("sim_cnt",        int'(bus.served_cnt), 2);

      // Back-to-back services and counter saturation
      pulseReset();
      #1 checkOutput("b2b_cnt_clr", int'(bus.served_cnt), 0);
      clearTally();
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 2'(i), 1'b1);
      repeat (3) applyStimulus(1'b1, 2'b00, 1'b0);
      @(posedge clk);
      checkOutput("b2b_grants", gnt_cycles, 5);
      checkOutput("b2b_cnt",    int'(bus.served_cnt), CNT_MAX);

      // Reset in the second grant cycle
      clearTally();
      applyStimulus(1'b0, 2'b10, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_gnt",  int'(bus.gnt),        0);
      checkOutput("mid_rst_busy", int'(bus.busy),       0);
      checkOutput("mid_rst_cnt",  int'(bus.served_cnt), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) applyStimulus(1'b1, 2'b00, 1'b0);
      @(posedge clk);
      checkOutput("mid_rst_timeouts", to_pulses, 0);
      checkOutput("mid_rst_cnt_after", int'(bus.served_cnt), 0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 2) == 0 ? 1'b1 : 1'b0,
                       2'($urandom_range(0, 3)),
                       $urandom_range(0, 5) == 0 ? 1'b1 : 1'b0);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end

      repeat (3) @(negedge clk);
      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
